// File: rtl/demux_1x8_dispatch.sv
// Registered 1-to-8 dispatcher: latches a producer word into the selected one-entry slot,
// and each slot hands its word to its own consumer with valid/ready.
//
// Per-slot state (one instance for each of the 8 slots):
//   state      | meaning
//   SLOT_EMPTY | no undelivered word; out_data holds the last delivered value
//   SLOT_FULL  | holds an undelivered word; out_valid asserted
module demux_1x8_dispatch #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [8*WIDTH-1:0] out_data,
  output logic [7:0]         out_valid,
  input  logic [7:0]         out_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   xfer_cnt
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  slot_state_e      state_q [8];
  slot_state_e      state_d [8];
  logic [WIDTH-1:0] data_q  [8];
  logic [WIDTH-1:0] data_d  [8];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic       sel_full;
  logic       accept;
  logic [7:0] load;
  logic [7:0] xfer;

  // Only the addressed slot can stall the producer; a draining slot may reload in the same cycle.
  always_comb begin
    sel_full = (state_q[in_sel] == SLOT_FULL);
    in_ready = ~reset & (~sel_full | out_ready[in_sel]);
    accept   = in_valid & in_ready;
    for (int k = 0; k < 8; k++) begin
      load[k] = accept & (in_sel == 3'(k));
      xfer[k] = (state_q[k] == SLOT_FULL) & out_ready[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) begin
        state_q[k] <= SLOT_EMPTY;
        data_q[k]  <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
      end
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];
      case (state_q[k])
        SLOT_EMPTY: begin
          if (load[k]) state_d[k] = SLOT_FULL;
        end
        SLOT_FULL: begin
          if (load[k])      state_d[k] = SLOT_FULL;
          else if (xfer[k]) state_d[k] = SLOT_EMPTY;
        end
        default: state_d[k] = SLOT_EMPTY;
      endcase
      if (load[k]) data_d[k] = in_data;
    end
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, accept};
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      out_valid[k]                  = (state_q[k] == SLOT_FULL);
      out_data[k*WIDTH +: WIDTH]    = data_q[k];
    end
    busy     = |out_valid;
    xfer_cnt = cnt_q;
  end

endmodule

// File: tb/tb_demux_1x8_dispatch.sv
// Bench for demux_1x8_dispatch: directed scenarios plus a random run, checked every cycle
// against a slot/queue model of the dispatcher.
module tb_demux_1x8_dispatch;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [63:0]  in_data = '0;
  logic [2:0]   in_sel = '0;
  logic         in_valid = 1'b0;
  logic [7:0]   out_ready = '0;

  logic         in_ready, busy;
  logic [511:0] out_data;
  logic [7:0]   out_valid;
  logic [15:0]  xfer_cnt;

  logic         in_ready4, busy4;
  logic [511:0] out_data4;
  logic [7:0]   out_valid4;
  logic [3:0]   xfer_cnt4;

  demux_1x8_dispatch #(.WIDTH(64), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .xfer_cnt(xfer_cnt)
  );

  demux_1x8_dispatch #(.WIDTH(64), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready4), .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .busy(busy4), .xfer_cnt(xfer_cnt4)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: slot contents plus, per channel, the queue of accepted-but-undelivered words.
  bit [7:0]    mv;
  logic [63:0] md [8];
  int unsigned mcnt;
  logic [63:0] sb [8][$];
  int          del_cnt [8];
  bit          model_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mv   = '0;
      mcnt = 0;
      for (int k = 0; k < 8; k++) begin
        md[k] = '0;
        sb[k].delete();
        del_cnt[k] = 0;
      end
      model_ok = 1'b1;
    end else begin
      bit acc;
      acc = in_valid && (!mv[in_sel] || out_ready[in_sel]);
      for (int k = 0; k < 8; k++) begin
        if (acc && in_sel == 3'(k)) begin
          mv[k] = 1'b1;
          md[k] = in_data;
          sb[k].push_back(in_data);
        end else if (mv[k] && out_ready[k]) begin
          mv[k] = 1'b0;
        end
      end
      if (acc) mcnt++;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("out_valid", 64'(out_valid), 64'(mv));
      check("out_valid_cnt4", 64'(out_valid4), 64'(mv));
      check("busy", 64'(busy), 64'(|out_valid));
      check("busy_model", 64'(busy), 64'(|mv));
      check("in_ready", 64'(in_ready), 64'(!reset && (!mv[in_sel] || out_ready[in_sel])));
      check("xfer_cnt", 64'(xfer_cnt), 64'(mcnt[15:0]));
      check("xfer_cnt4", 64'(xfer_cnt4), 64'(mcnt[3:0]));
      for (int k = 0; k < 8; k++) begin
        check($sformatf("out_data_ch%0d", k), out_data[k*64 +: 64], md[k]);
        if (!reset && out_valid[k] && out_ready[k]) begin
          if (sb[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deliver_ch%0d: got word %h expected no word pending", k, out_data[k*64 +: 64]);
          end else begin
            check($sformatf("deliver_order_ch%0d", k), out_data[k*64 +: 64], sb[k].pop_front());
            del_cnt[k]++;
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit stalled;

    // reset for two cycles
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'h00);
    check("rst_data_zero", 64'(|out_data), 64'h0);
    check("rst_xfer_cnt", 64'(xfer_cnt), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    for (int s = 0; s < 8; s++) begin
      in_sel = 3'(s);
      #1;
      check($sformatf("rst_in_ready_sel%0d", s), 64'(in_ready), 64'h1);
    end

    // single accept into slot 5
    in_data   = 64'hDEAD_BEEF_0000_0005;
    in_sel    = 3'd5;
    in_valid  = 1'b1;
    out_ready = 8'h00;
    tick;
    in_valid = 1'b0;
    check("t2_out_valid", 64'(out_valid), 64'h20);
    check("t2_ch5_data", out_data[5*64 +: 64], 64'hDEAD_BEEF_0000_0005);
    check("t2_xfer_cnt", 64'(xfer_cnt), 64'h1);
    in_sel = 3'd5;
    #1;
    check("t2_ready_sel5", 64'(in_ready), 64'h0);
    in_sel = 3'd2;
    #1;
    check("t2_ready_sel2", 64'(in_ready), 64'h1);

    // reload a full slot while it drains
    in_sel   = 3'd3;
    in_data  = 64'hAAAA;
    in_valid = 1'b1;
    tick;
    out_ready = 8'h08;
    in_data   = 64'h1234;
    #1;
    check("t3_in_ready", 64'(in_ready), 64'h1);
    tick;
    in_valid  = 1'b0;
    out_ready = 8'h00;
    check("t3_valid3", 64'(out_valid[3]), 64'h1);
    check("t3_ch3_data", out_data[3*64 +: 64], 64'h1234);
    check("t3_xfer_cnt", 64'(xfer_cnt), 64'h3);
    out_ready = 8'hFF;
    tick;
    out_ready = 8'h00;

    // 100-word round-robin stream
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    out_ready = 8'hFF;
    for (int i = 0; i < 100; i++) begin
      in_sel   = 3'(i % 8);
      in_data  = {32'hC0DE_0000, 32'(i)};
      in_valid = 1'b1;
      #1;
      check("t4_in_ready", 64'(in_ready), 64'h1);
      tick;
    end
    in_valid = 1'b0;
    tick;
    check("t4_xfer_cnt", 64'(xfer_cnt), 64'd100);
    for (int k = 0; k < 8; k++)
      check($sformatf("t4_words_ch%0d", k), 64'(del_cnt[k]), (k < 4) ? 64'd13 : 64'd12);

    // random traffic; producer holds its word while stalled
    stalled = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!stalled) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 3'($urandom_range(0, 7));
        in_data  = {$urandom, $urandom};
      end
      out_ready = 8'($urandom);
      #1;
      stalled = in_valid && !in_ready;
      tick;
    end
    in_valid  = 1'b0;
    out_ready = 8'hFF;
    tick;
    tick;
    check("t5_drained", 64'(out_valid), 64'h00);

    // reset with four slots full
    out_ready = 8'h00;
    for (int s = 0; s < 4; s++) begin
      in_sel   = 3'(s);
      in_data  = {$urandom, $urandom};
      in_valid = 1'b1;
      tick;
    end
    check("t6_four_full", 64'(out_valid), 64'h0F);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_sel   = 3'd6;
    #1;
    check("t6_ready_in_reset", 64'(in_ready), 64'h0);
    tick;
    check("t6_valid_cleared", 64'(out_valid), 64'h00);
    check("t6_cnt_cleared", 64'(xfer_cnt), 64'h0);
    check("t6_data_cleared", 64'(|out_data), 64'h0);
    reset     = 1'b0;
    out_ready = 8'hFF;
    for (int i = 0; i < 17; i++) begin
      in_sel   = 3'(i % 8);
      in_data  = 64'(i + 1);
      in_valid = 1'b1;
      tick;
    end
    in_valid = 1'b0;
    check("t6_cnt4_wrap", 64'(xfer_cnt4), 64'h1);
    check("t6_cnt16", 64'(xfer_cnt), 64'd17);
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
